mux41_scan_reader: RTL and testbench

- Sequential reader that sits on the far side of a 4x1 tri-state mux (decoder plus tri-state buffers) and reads all four mux inputs back through the single-bit Y line.
- Drives sel and en into the mux and walks sel through 0..3.
- Waits a configurable settle time on each slot, then samples Y.
- Reassembles the four samples into a 4-bit word and presents it with a one-cycle valid strobe; supports single-shot and continuous scanning.

---
 rtl/mux41_scan_reader.sv | 121 ++++++++++++
 tb/tb_mux41_scan_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux41_scan_reader.sv
// mux41_scan_reader
// Reads the four inputs of a 4x1 tri-state mux back through its single Y
// line. The reader drives sel/en, waits SETTLE cycles on each slot so Y is
// stable before sampling, and collects the four samples into one word.
// Each finished word is published with a one-cycle data_valid strobe, plus
// a changed strobe when it differs from the previous word. The reader can
// run one scan per start pulse, or keep scanning back-to-back while cont=1.
// All outputs come straight from flops, so y/start/cont never reach an
// output combinationally.

module mux41_scan_reader #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       y,
    output logic [1:0] sel,
    output logic       en,
    output logic [3:0] data,
    output logic       data_valid,
    output logic       changed,
    output logic       busy
);

    // The settle counter is 4 bits wide, so SETTLE must fit in 1..15.
    if (SETTLE < 1 || SETTLE > 15) begin : gen_settle_range_check
        $error("mux41_scan_reader: SETTLE must be within 1..15");
    end

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [1:0] sel_q;
    logic       en_q;
    logic [2:0] shadow_q;
    logic [3:0] data_q;
    logic       data_valid_q;
    logic       changed_q;
    logic       busy_q;

    // Word that will be published on the last-slot edge: the live Y sample
    // for slot 3 on top of the three shadowed samples.
    logic [3:0] word_d;
    assign word_d = {y, shadow_q};

    // Scan sequencer: walks sel through 0..3, holds each slot SETTLE cycles,
    // captures Y into the shadow bits, and publishes the word on slot 3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            sel_q        <= 2'd0;
            en_q         <= 1'b0;
            shadow_q     <= 3'd0;
            data_q       <= 4'd0;
            data_valid_q <= 1'b0;
            changed_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            changed_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SCAN;
                        en_q    <= 1'b1;
                        sel_q   <= 2'd0;
                        cnt_q   <= CNT_RELOAD;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (sel_q != 2'd3) begin
                        case (sel_q)
                            2'd0:    shadow_q[0] <= y;
                            2'd1:    shadow_q[1] <= y;
                            default: shadow_q[2] <= y;
                        endcase
                        sel_q <= sel_q + 2'd1;
                        cnt_q <= CNT_RELOAD;
                    end else begin
                        data_q       <= word_d;
                        data_valid_q <= 1'b1;
                        changed_q    <= (word_d != data_q);
                        sel_q        <= 2'd0;
                        cnt_q        <= CNT_RELOAD;
                        if (!cont) begin
                            state_q <= IDLE;
                            en_q    <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    en_q    <= 1'b0;
                    sel_q   <= 2'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sel        = sel_q;
    assign en         = en_q;
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign changed    = changed_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mux41_scan_reader.sv
// tb_mux41_scan_reader
// Two readers share one clock and reset: one with SETTLE=1 and one with
// SETTLE=3, each on the far side of its own tri-state mux model. The
// stimulus side pushes the word each scan should return into a per-reader
// queue; a monitor pops and compares whenever data_valid is seen.

module tb_mux41_scan_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       startS [2];
    logic       contS  [2];
    logic [3:0] inS    [2];

    logic [1:0] selS   [2];
    logic       enS    [2];
    logic [3:0] dataS  [2];
    logic       dvS    [2];
    logic       chS    [2];
    logic       busyS  [2];

    wire y0w;
    wire y1w;

    logic [4:0] q0 [$];
    logic [4:0] q1 [$];
    logic [3:0] lastWord [2];

    int total = 0;
    int bad   = 0;

    // The mux under observation: Y follows the selected input while enabled
    // and floats otherwise.
    assign y0w = enS[0] ? inS[0][selS[0]] : 1'bz;
    assign y1w = enS[1] ? inS[1][selS[1]] : 1'bz;

    mux41_scan_reader #(.SETTLE(1)) u_s1 (
        .clk        (clk),
        .rst        (rst),
        .start      (startS[0]),
        .cont       (contS[0]),
        .y          (y0w),
        .sel        (selS[0]),
        .en         (enS[0]),
        .data       (dataS[0]),
        .data_valid (dvS[0]),
        .changed    (chS[0]),
        .busy       (busyS[0])
    );

    mux41_scan_reader #(.SETTLE(3)) u_s3 (
        .clk        (clk),
        .rst        (rst),
        .start      (startS[1]),
        .cont       (contS[1]),
        .y          (y1w),
        .sel        (selS[1]),
        .en         (enS[1]),
        .data       (dataS[1]),
        .data_valid (dvS[1]),
        .changed    (chS[1]),
        .busy       (busyS[1])
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    function automatic int settleOf(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the published word is simply the four mux inputs,
    // and changed is whether it differs from the last word that reader
    // published.
    task automatic pushExp(input int k, input logic [3:0] w);
        logic c;
        c = (w != lastWord[k]);
        lastWord[k] = w;
        if (k == 0) q0.push_back({c, w});
        else        q1.push_back({c, w});
    endtask

    // Monitor: every data_valid must match the oldest pending expectation,
    // and changed may only appear alongside data_valid.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (dvS[k]) begin
                logic [4:0] e;
                if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_valid%0d actual=1 expected=0 t=%0t", k, $time);
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    checkOutput($sformatf("data%0d", k), int'(dataS[k]), int'(e[3:0]));
                    checkOutput($sformatf("changed%0d", k), int'(chS[k]), int'(e[4]));
                end
            end else begin
                checkOutput($sformatf("changed_no_valid%0d", k), int'(chS[k]), 0);
            end
        end
    end

    // One single-shot scan on reader k returning word w. When pulseN is
    // non-negative, start is re-asserted during scan cycle pulseN and must
    // be ignored.
    task automatic applyStimulus(input int k, input logic [3:0] w, input int pulseN);
        int s;
        s = settleOf(k);
        inS[k] = w;
        @(negedge clk);
        startS[k] = 1'b1;
        pushExp(k, w);
        @(negedge clk);
        startS[k] = 1'b0;
        for (int n = 0; n < 4 * s; n++) begin
            checkOutput($sformatf("scan_sel%0d", k), int'(selS[k]), n / s);
            checkOutput($sformatf("scan_en%0d", k), int'(enS[k]), 1);
            checkOutput($sformatf("scan_busy%0d", k), int'(busyS[k]), 1);
            startS[k] = (n == pulseN);
            @(negedge clk);
        end
        startS[k] = 1'b0;
        checkOutput($sformatf("done_valid%0d", k), int'(dvS[k]), 1);
        checkOutput($sformatf("done_en%0d", k), int'(enS[k]), 0);
        checkOutput($sformatf("done_busy%0d", k), int'(busyS[k]), 0);
        checkOutput($sformatf("done_sel%0d", k), int'(selS[k]), 0);
        @(negedge clk);
        checkOutput($sformatf("after_en%0d", k), int'(enS[k]), 0);
        checkOutput($sformatf("after_valid%0d", k), int'(dvS[k]), 0);
    endtask

    task automatic checkResetState(input string tag);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s_sel%0d", tag, k), int'(selS[k]), 0);
            checkOutput($sformatf("%s_en%0d", tag, k), int'(enS[k]), 0);
            checkOutput($sformatf("%s_data%0d", tag, k), int'(dataS[k]), 0);
            checkOutput($sformatf("%s_valid%0d", tag, k), int'(dvS[k]), 0);
            checkOutput($sformatf("%s_busy%0d", tag, k), int'(busyS[k]), 0);
        end
    endtask

    initial begin
        logic [3:0] frames [5];

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            startS[k]   = 1'b0;
            contS[k]    = 1'b0;
            inS[k]      = 4'd0;
            lastWord[k] = 4'd0;
        end
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single shot, SETTLE=1");
        applyStimulus(0, 4'b1010, -1);
        repeat (3) applyStimulus(0, 4'($urandom_range(0, 15)), -1);

        $display("[TB] settle timing, SETTLE=3");
        applyStimulus(1, 4'b0101, -1);
        applyStimulus(1, 4'b0101, -1);
        repeat (2) applyStimulus(1, 4'($urandom_range(0, 15)), -1);

        $display("[TB] continuous mode, SETTLE=1");
        frames[0] = 4'b0110;
        frames[1] = 4'b0000;
        for (int f = 2; f < 5; f++) frames[f] = 4'($urandom_range(0, 15));
        inS[0]   = frames[0];
        contS[0] = 1'b1;
        @(negedge clk);
        startS[0] = 1'b1;
        pushExp(0, frames[0]);
        @(negedge clk);
        startS[0] = 1'b0;
        for (int f = 0; f < 5; f++) begin
            for (int n = 0; n < 4; n++) begin
                checkOutput("cont_en", int'(enS[0]), 1);
                checkOutput("cont_sel", int'(selS[0]), n);
                if (f == 4 && n == 1) contS[0] = 1'b0;
                @(negedge clk);
            end
            checkOutput("cont_valid", int'(dvS[0]), 1);
            if (f < 4) begin
                checkOutput("cont_en_gap", int'(enS[0]), 1);
                checkOutput("cont_busy", int'(busyS[0]), 1);
                inS[0] = frames[f + 1];
                pushExp(0, frames[f + 1]);
            end else begin
                checkOutput("cont_stop_en", int'(enS[0]), 0);
                checkOutput("cont_stop_busy", int'(busyS[0]), 0);
            end
        end
        @(negedge clk);

        $display("[TB] ignored start");
        applyStimulus(0, 4'($urandom_range(0, 15)), 2);
        applyStimulus(0, 4'($urandom_range(0, 15)), 3);
        applyStimulus(1, 4'($urandom_range(0, 15)), 7);
        applyStimulus(1, 4'($urandom_range(0, 15)), 11);

        $display("[TB] reset mid-operation");
        inS[0] = 4'b0110;
        @(negedge clk);
        startS[0] = 1'b1;
        @(negedge clk);
        startS[0] = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_sel", int'(selS[0]), 2);
        checkOutput("pre_reset_en", int'(enS[0]), 1);
        #2 rst = 1'b1;
        #1 checkResetState("async_reset");
        lastWord[0] = 4'd0;
        lastWord[1] = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_valid", int'(dvS[0]), 0);
        applyStimulus(0, 4'b0110, -1);

        repeat (4) @(negedge clk);
        checkOutput("queue0_empty", q0.size(), 0);
        checkOutput("queue1_empty", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
